// File: rtl/fir_lowpass_mac_if.sv
// Sample/coefficient bus between the DAC-path producer and fir_lowpass_mac.
//   master : drives i_din_valid, i_din, i_coef_we, i_coef_addr, i_coef_data;
//            observes o_dout, o_dout_valid, o_busy, o_overrun.
//   slave  : the filter side of the same signals.
interface fir_lowpass_mac_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned COEF_W = 16
);
  logic              i_din_valid;
  logic [DATA_W-1:0] i_din;
  logic              i_coef_we;
  logic [5:0]        i_coef_addr;
  logic [COEF_W-1:0] i_coef_data;
  logic [DATA_W-1:0] o_dout;
  logic              o_dout_valid;
  logic              o_busy;
  logic              o_overrun;

  modport master (
    output i_din_valid, i_din, i_coef_we, i_coef_addr, i_coef_data,
    input  o_dout, o_dout_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_din_valid, i_din, i_coef_we, i_coef_addr, i_coef_data,
    output o_dout, o_dout_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/fir_lowpass_mac.sv
// Time-multiplexed single-multiplier FIR low-pass filter feeding the I2S DAC serializer.
// One sample in, TAPS MAC cycles, one round cycle, one output cycle (latency TAPS+2).
//   i_clk   : MCLK domain clock
//   i_rst_n : asynchronous active-low reset
//   bus     : fir_lowpass_mac_if.slave (sample in, coefficient port, result/status out)
// Build option: define FIR_SATURATE_EN to clamp the result to the DATA_W signed range;
// otherwise the result wraps to its low DATA_W bits.
module fir_lowpass_mac #(
  parameter int unsigned TAPS   = 31,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned COEF_W = 16
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fir_lowpass_mac_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(1) << (COEF_W - 2);
  localparam logic [COEF_W-1:0]       COEF_ONE = {1'b0, {(COEF_W - 1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StMac, StRound, StDone} state_e;

  state_e                   state_q;
  logic [IDX_W-1:0]         wptr_q, ridx_q, k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        dout_q;
  logic                     dout_valid_q, busy_q, overrun_q;
  logic                     pend_q;
  logic [IDX_W-1:0]         pend_addr_q;
  logic [COEF_W-1:0]        pend_data_q;
  logic signed [DATA_W-1:0] dline_q [TAPS];
  logic signed [COEF_W-1:0] coef_q  [TAPS];

  logic                     accept, coef_hit;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  rounded;
  logic [DATA_W-1:0]        narrowed;

  assign accept   = (state_q == StIdle) && bus.i_din_valid;
  assign coef_hit = (state_q == StIdle) && bus.i_coef_we && (32'(bus.i_coef_addr) < TAPS);

  // Size casts sign-extend both operands so the product is full precision.
  assign prod    = PROD_W'(coef_q[k_q]) * PROD_W'(dline_q[ridx_q]);
  assign rounded = (acc_q + HALF_LSB) >>> (COEF_W - 1);

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'($signed({1'b0, {(DATA_W - 1){1'b1}}}));
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'($signed({1'b1, {(DATA_W - 1){1'b0}}}));

  always_comb begin
    narrowed = acc_q[DATA_W-1:0];
    if (acc_q > SAT_MAX) begin
      narrowed = SAT_MAX[DATA_W-1:0];
    end else if (acc_q < SAT_MIN) begin
      narrowed = SAT_MIN[DATA_W-1:0];
    end
  end
`else
  assign narrowed = acc_q[DATA_W-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      ridx_q       <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (bus.i_din_valid && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.i_din_valid) begin
            // Newest sample lands at wptr; the MAC walks backwards from there.
            ridx_q  <= wptr_q;
            wptr_q  <= (wptr_q == LAST_IDX) ? '0 : wptr_q + IDX_W'(1);
            k_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q  <= acc_q + ACC_W'(prod);
          ridx_q <= (ridx_q == '0) ? LAST_IDX : ridx_q - IDX_W'(1);
          k_q    <= k_q + IDX_W'(1);
          if (k_q == LAST_IDX) begin
            state_q <= StRound;
          end
        end
        StRound: begin
          acc_q   <= rounded;
          state_q <= StDone;
        end
        StDone: begin
          dout_q       <= narrowed;
          dout_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
      end
    end else if (accept) begin
      dline_q[wptr_q] <= bus.i_din;
    end
  end

  // A write arriving with an accepted sample is parked until that sample's DONE
  // so the computation in flight keeps the old coefficient set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= (i == 0) ? COEF_ONE : '0;
      end
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else if (coef_hit) begin
      if (bus.i_din_valid) begin
        pend_q      <= 1'b1;
        pend_addr_q <= IDX_W'(bus.i_coef_addr);
        pend_data_q <= bus.i_coef_data;
      end else begin
        coef_q[IDX_W'(bus.i_coef_addr)] <= bus.i_coef_data;
      end
    end else if (pend_q && (state_q == StDone)) begin
      coef_q[pend_addr_q] <= pend_data_q;
      pend_q              <= 1'b0;
    end
  end

  assign bus.o_dout       = dout_q;
  assign bus.o_dout_valid = dout_valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_overrun    = overrun_q;
endmodule

// File: tb/tb_fir_lowpass_mac.sv
// Directed self-checking bench for fir_lowpass_mac (TAPS=31, DATA_W=24, COEF_W=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fir_lowpass_mac;
  localparam int LAT = 33;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fir_lowpass_mac_if #(.DATA_W(24), .COEF_W(16)) bus ();

  fir_lowpass_mac #(.TAPS(31), .DATA_W(24), .COEF_W(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_coef(input logic [5:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = addr;
    bus.i_coef_data = data;
    @(negedge clk);
    bus.i_coef_we   = 1'b0;
  endtask

  task automatic send_sample(input logic [23:0] x);
    @(negedge clk);
    bus.i_din_valid = 1'b1;
    bus.i_din       = x;
    @(negedge clk);
    bus.i_din_valid = 1'b0;
  endtask

  // Counts falling edges after the acceptance edge; lat = -1 on timeout.
  task automatic wait_valid(input int start, output int lat, output logic [23:0] d);
    lat = -1;
    d   = '0;
    for (int c = start + 1; c <= start + 100; c++) begin
      @(negedge clk);
      if (bus.o_dout_valid) begin
        lat = c;
        d   = bus.o_dout;
        break;
      end
    end
  endtask

  task automatic finish_result(input string tag, input int start, input logic [23:0] exp);
    int          lat;
    logic [23:0] d;
    wait_valid(start, lat, d);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_dout"}, 32'(d), 32'(exp));
    check({tag, "_busy_low"}, 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.o_dout_valid), 32'd0);
    check({tag, "_hold"}, 32'(bus.o_dout), 32'(exp));
  endtask

  task automatic run_sample(input string tag, input logic [23:0] x, input logic [23:0] exp);
    send_sample(x);
    check({tag, "_busy_high"}, 32'(bus.o_busy), 32'd1);
    finish_result(tag, 0, exp);
  endtask

  initial begin
    int          lat;
    logic [23:0] d;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.i_din_valid = 1'b0;
    bus.i_din       = '0;
    bus.i_coef_we   = 1'b0;
    bus.i_coef_addr = '0;
    bus.i_coef_data = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(bus.o_dout), 32'd0);
    check("rst_valid", 32'(bus.o_dout_valid), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_overrun", 32'(bus.o_overrun), 32'd0);
    rst_n = 1'b1;

    // Impulse through the reset coefficient set (coef[0]=0x7FFF).
    run_sample("imp", 24'h100000, 24'h0FFFE0);
    run_sample("zero1", 24'h000000, 24'h000000);
    run_sample("zero2", 24'h000000, 24'h000000);

    // Boxcar of 0x0400: each extra sample adds 2^28 >> 15 = 0x2000.
    do_reset();
    for (int i = 0; i < 31; i++) write_coef(6'(i), 16'h0400);
    for (int m = 1; m <= 32; m++) begin
      repeat (200) @(negedge clk);
      run_sample($sformatf("ramp%0d", m), 24'h040000, 24'((m > 31 ? 31 : m) * 32'h2000));
    end

    // Two full-scale samples through coef[0]=coef[1]=0x7FFF.
    do_reset();
    write_coef(6'd1, 16'h7FFF);
    run_sample("fs1", 24'h7FFFFF, 24'h7FFEFF);
`ifdef FIR_SATURATE_EN
    run_sample("fs2", 24'h7FFFFF, 24'h7FFFFF);
`else
    run_sample("fs2", 24'h7FFFFF, 24'hFFFDFE);
`endif

    // Overrun: second strobe 5 cycles into the MAC must be dropped.
    do_reset();
    write_coef(6'd1, 16'h4000);
    send_sample(24'h100000);
    repeat (4) @(negedge clk);
    bus.i_din_valid = 1'b1;
    bus.i_din       = 24'h200000;
    @(negedge clk);
    bus.i_din_valid = 1'b0;
    check("ovr_flag", 32'(bus.o_overrun), 32'd1);
    finish_result("ovr_first", 5, 24'h0FFFE0);
    // x[n-1] must still be 0x100000 (dropped sample never written): 0.5 * 0x100000.
    run_sample("ovr_next", 24'h000000, 24'h080000);
    check("ovr_sticky", 32'(bus.o_overrun), 32'd1);

    // Coefficient writes: ignored while busy, deferred when coincident with a sample.
    do_reset();
    check("ovr_cleared", 32'(bus.o_overrun), 32'd0);
    send_sample(24'h100000);
    repeat (3) @(negedge clk);
    write_coef(6'd0, 16'h4000);
    finish_result("cw_busy", 5, 24'h0FFFE0);
    run_sample("cw_ignored", 24'h100000, 24'h0FFFE0);
    @(negedge clk);
    bus.i_din_valid = 1'b1;
    bus.i_din       = 24'h100000;
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = 6'd0;
    bus.i_coef_data = 16'h4000;
    @(negedge clk);
    bus.i_din_valid = 1'b0;
    bus.i_coef_we   = 1'b0;
    finish_result("cw_same", 0, 24'h0FFFE0);
    run_sample("cw_applied", 24'h100000, 24'h080000);

    // Reset mid-MAC: outputs cleared, no valid, coefficients restored.
    send_sample(24'h100000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", 32'(bus.o_dout), 32'd0);
    check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    check("mid_rst_overrun", 32'(bus.o_overrun), 32'd0);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (bus.o_dout_valid) lat++;
    end
    check("mid_rst_no_valid", 32'(lat), 32'd0);
    run_sample("post_rst_imp", 24'h100000, 24'h0FFFE0);
    d = bus.o_dout;
    check("post_rst_dout", 32'(d), 32'h0FFFE0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fir_lowpass_mac.md
# fir_lowpass_mac

Time-multiplexed, single-multiplier FIR low-pass filter in the DAC path, directly upstream of the I2S DAC serializer. It accepts one signed 24-bit audio sample per frame and computes the filtered result over TAPS+2 clock cycles. It presents the result on a stable output register, which the serializer captures at its own sample strobe. Coefficients are runtime-writable through a simple register port.

## Interface
- TAPS, 31: number of filter taps (2..64); delay line and coefficient file depth.
- DATA_W, 24: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed Q1.(COEF_W-1).
- i_clk  in  1  12 MHz MCLK domain clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_din_valid  in  1  one-cycle strobe: i_din is a new sample.
- i_din  in  DATA_W  input sample.
- i_coef_we  in  1  coefficient write enable.
- i_coef_addr  in  6  tap index 0..TAPS-1; out-of-range writes are ignored.
- i_coef_data  in  COEF_W  coefficient value.
- o_dout  out  DATA_W  filtered sample, held until the next DONE; connects to the serializer's 24-bit sample input.
- o_dout_valid  out  1  one-cycle pulse when o_dout updates.
- o_busy  out  1  high in MAC, ROUND and DONE.
- o_overrun  out  1  sticky; set when a sample is dropped.

## Operation
- Reset state:
  - o_dout=0, o_dout_valid=0, o_busy=0, o_overrun=0.
  - Delay line all zero; write pointer 0.
  - Coefficients: coef[0]=0x7FFF, all others 0 (near-passthrough).
- Delay line:
  - Circular buffer of TAPS samples.
  - An accepted sample is written at wptr. wptr then advances and wraps TAPS-1 → 0.
  - x[n-k] is read at (newest_idx - k) mod TAPS.
- FSM states:
  - IDLE: i_din_valid → store sample, clear accumulator, k=0, go to MAC.
  - MAC: acc += coef[k] * x[n-k], one product per cycle. After k=TAPS-1, go to ROUND.
  - ROUND: acc += 2^(COEF_W-2), then arithmetic shift right by COEF_W-1.
  - DONE: register o_dout, pulse o_dout_valid, return to IDLE.
- Arithmetic:
  - Product width is DATA_W+COEF_W.
  - Accumulator width is DATA_W+COEF_W+clog2(TAPS) (45 bits at defaults); it never overflows internally.
  - Rounding is round-half-up.
  - Narrowing the result to DATA_W is governed by FIR_SATURATE_EN (see Configuration).
- Coefficient writes:
  - Accepted only in IDLE.
  - A write while o_busy=1 is ignored.
  - A write in the same cycle as an accepted i_din_valid takes effect from the next sample, not the current one.
- Overrun:
  - i_din_valid while o_busy=1 drops the sample: delay line and wptr are unchanged, and o_overrun is set.
  - o_overrun clears only on reset.
- Reset asserted mid-MAC aborts the computation and restores every reset value. No o_dout_valid is issued.

## Timing
- Sample accepted at edge T0 (valid high in IDLE).
- MAC runs edges T1..T_TAPS.
- ROUND at T_TAPS+1; DONE at T_TAPS+2.
- o_dout and o_dout_valid change at that DONE edge: latency TAPS+2 cycles (33 at default).
- o_dout is stable for every cycle outside the DONE edge. The downstream serializer may sample it at any time without a handshake.
- Maximum sustained input rate is one sample per TAPS+3 cycles. The I2S frame is 250 cycles, so TAPS ≤ 64 always fits.
- o_busy rises the cycle after acceptance and falls the cycle after DONE.

## Configuration
- FIR_SATURATE_EN:
  - Defined: the rounded, shifted value clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. 0x800000..0x7FFFFF.
  - Undefined: the value is truncated to its low DATA_W bits (two's-complement wrap), and the clamp logic is not built.

## Test plan
- Reset coefficients, single impulse i_din=0x100000 → o_dout=0x0FFFE0 exactly 33 cycles later; following samples of 0 → o_dout=0.
- Write coef[0..30]=0x0400 in IDLE, feed 31 samples of 0x040000 spaced 250 cycles → output ramps by 0x002000 per sample and holds 0x03E000 from the 31st.
- coef[0]=coef[1]=0x7FFF, two samples 0x7FFFFF → second o_dout=0x7FFFFF with FIR_SATURATE_EN, 0xFFFDFE without.
- i_din_valid again 5 cycles after acceptance → sample dropped, o_overrun=1, first result unaffected, wptr unchanged.
- Coefficient write during MAC → ignored (read back via an impulse response); write in IDLE → applied to the next sample.
- Assert i_rst_n low at MAC cycle 10 → all outputs 0, no o_dout_valid; the next impulse after release behaves as the first scenario.
